// File: rtl/ddr_readout_pkg.sv
// Shared types for the DDR2 range-readout/fill engine: mode encoding, FSM states
// and the per-mode entry state.
package ddr_readout_pkg;

  typedef enum logic [1:0] {
    MODE_READ       = 2'd0,
    MODE_FILL       = 2'd1,
    MODE_READ_CLEAR = 2'd2,
    MODE_NOP        = 2'd3
  } mode_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    TX_SEND,
    TX_WAIT,
    WR_REQ,
    WR_WAIT,
    NEXT,
    DONE
  } state_t;

  function automatic state_t first_state(input mode_t m);
    return (m == MODE_READ || m == MODE_READ_CLEAR) ? RD_REQ : WR_REQ;
  endfunction

endpackage

// File: rtl/ddr_readout_engine_if.sv
// Memory-controller user port plus UART TX handshake seen by the readout engine.
interface ddr_readout_engine_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rw;
  logic              mem_op;

  modport master (
    input  tx_ready, mem_ready, mem_rdata, mem_rvalid,
    output tx_data, tx_valid, mem_addr, mem_wdata, mem_rw, mem_op
  );

  modport slave (
    output tx_ready, mem_ready, mem_rdata, mem_rvalid,
    input  tx_data, tx_valid, mem_addr, mem_wdata, mem_rw, mem_op
  );
endinterface

// File: rtl/ddr_cmd_issuer.sv
// Waits for mem_ready, then holds one memory command for CMD_CYCLES cycles with
// address/direction/data frozen. fin marks the last held cycle.
module ddr_cmd_issuer #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CMD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_ready,
  output logic              fin,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  output logic              mem_op
);

  localparam logic [3:0] LAST_CNT = 4'(CMD_CYCLES - 1);

  logic       active;
  logic [3:0] cnt;

  assign fin = active && (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active    <= 1'b0;
      cnt       <= '0;
      mem_op    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b1;
    end else if (active) begin
      if (cnt == LAST_CNT) begin
        active <= 1'b0;
        mem_op <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else if (go && mem_ready) begin
      active    <= 1'b1;
      mem_op    <= 1'b1;
      cnt       <= '0;
      mem_addr  <= addr;
      mem_wdata <= wdata;
      mem_rw    <= rw;
    end
  end

endmodule

// File: rtl/ddr_readout_engine.sv
// DDR2 range engine: streams a word range to the UART, fills it with a pattern,
// or reads-then-clears each word; abortable at word boundaries.
module ddr_readout_engine
  import ddr_readout_pkg::*;
#(
  parameter int unsigned ADDR_W       = 30,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_STEP    = 4,
  parameter int unsigned CMD_CYCLES   = 2,
  parameter int unsigned MEM_MAX_ADDR = 16777212
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_end,
  input  logic [DATA_W-1:0] fill_pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] word_count,
  ddr_readout_engine_if.master bus
);

  localparam int unsigned       CW         = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(ADDR_STEP - 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(MEM_MAX_ADDR);
  localparam logic [CW-1:0]     STEP       = CW'(ADDR_STEP);

  state_t state, state_nx;
  mode_t  mode_q;

  // One extra bit so stepping past the top of the address space cannot wrap.
  logic [CW-1:0]     cur, last;
  logic [DATA_W-1:0] pattern_q, tx_data_q;
  logic              skip, tx_valid_q;
  logic [ADDR_W-1:0] start_cur, start_last;
  logic              issue_go, issue_rw, issue_fin;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_rw, cmd_op;

  assign start_cur  = addr_start & ALIGN_MASK;
  assign start_last = ((addr_end > MAX_ADDR) ? MAX_ADDR : addr_end) & ALIGN_MASK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = first_state(mode_t'(mode));
      RD_REQ:  if (skip) state_nx = DONE; else if (issue_fin) state_nx = RD_WAIT;
      RD_WAIT: if (bus.mem_rvalid) state_nx = TX_SEND;
      TX_SEND: if (bus.tx_ready) state_nx = TX_WAIT;
      TX_WAIT: if (!bus.tx_ready) state_nx = (mode_q == MODE_READ_CLEAR) ? WR_REQ : NEXT;
      WR_REQ:  if (skip) state_nx = DONE; else if (issue_fin) state_nx = WR_WAIT;
      WR_WAIT: if (bus.mem_ready) state_nx = NEXT;
      NEXT:    state_nx = (cur == last || abort) ? DONE : first_state(mode_q);
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE) && (state != DONE);
    done     = (state == DONE);
    issue_go = (state == RD_REQ || state == WR_REQ) && !skip;
    issue_rw = (state == RD_REQ);
  end

  // Empty ranges and the reserved mode enter a request state with skip set so
  // they report done with the same latency as a real run, without issuing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= '0;
      last       <= '0;
      mode_q     <= MODE_READ;
      pattern_q  <= '0;
      skip       <= 1'b0;
      word_count <= '0;
      aborted    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= (state == TX_SEND) && bus.tx_ready;
      if (state == IDLE && start) begin
        cur        <= {1'b0, start_cur};
        last       <= {1'b0, start_last};
        mode_q     <= mode_t'(mode);
        pattern_q  <= fill_pattern;
        skip       <= (start_cur > start_last) || (mode_t'(mode) == MODE_NOP);
        word_count <= '0;
        aborted    <= 1'b0;
      end
      if (state == RD_WAIT && bus.mem_rvalid) tx_data_q <= bus.mem_rdata;
      if (state == NEXT) begin
        word_count <= word_count + ADDR_W'(1);
        if (abort)            aborted <= 1'b1;
        else if (cur != last) cur     <= cur + STEP;
      end
    end
  end

  ddr_cmd_issuer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CMD_CYCLES (CMD_CYCLES)
  ) u_issuer (
    .clk       (clk),
    .reset     (reset),
    .go        (issue_go),
    .rw        (issue_rw),
    .addr      (cur[ADDR_W-1:0]),
    .wdata     (pattern_q),
    .mem_ready (bus.mem_ready),
    .fin       (issue_fin),
    .mem_addr  (cmd_addr),
    .mem_wdata (cmd_wdata),
    .mem_rw    (cmd_rw),
    .mem_op    (cmd_op)
  );

  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.mem_rw    = cmd_rw;
  assign bus.mem_op    = cmd_op;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_ddr_readout_engine.sv
// Bench for ddr_readout_engine: behavioural DDR and UART models on the falling
// edge, a vector table of range runs, then abort/timing/reset sequences.
module tb_ddr_readout_engine;
  import ddr_readout_pkg::*;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [29:0] addr_start = '0, addr_end = '0;
  logic [31:0] fill_pattern = '0;
  logic        busy, done, aborted;
  logic [29:0] word_count;

  ddr_readout_engine_if #(.ADDR_W(30), .DATA_W(32)) bus();

  ddr_readout_engine #(
    .ADDR_W(30), .DATA_W(32), .ADDR_STEP(4), .CMD_CYCLES(2), .MEM_MAX_ADDR(16777212)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .addr_start(addr_start), .addr_end(addr_end), .fill_pattern(fill_pattern),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .word_count(word_count), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] mem [logic [29:0]];
  int          ev_q[$];
  logic [31:0] tx_q[$];
  logic [29:0] wr_a[$];
  logic [31:0] wr_d[$];
  int n_rd = 0, n_wr = 0, n_tx = 0, n_done = 0, uart_hold = 0;
  bit op_prev = 1'b0, pend = 1'b0;
  logic [29:0] paddr = '0;

  always @(negedge clk) begin
    if (done) n_done++;
    bus.mem_rvalid = 1'b0;
    if (reset) pend = 1'b0;
    if (bus.mem_op && !op_prev) begin
      if (bus.mem_rw) begin
        n_rd++; pend = 1'b1; paddr = bus.mem_addr;
        ev_q.push_back((1 << 16) | int'(bus.mem_addr[15:0]));
      end else begin
        n_wr++; mem[bus.mem_addr] = bus.mem_wdata;
        wr_a.push_back(bus.mem_addr); wr_d.push_back(bus.mem_wdata);
        ev_q.push_back((2 << 16) | int'(bus.mem_addr[15:0]));
      end
    end else if (!bus.mem_op && op_prev && pend) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem.exists(paddr) ? mem[paddr] : 32'h0;
      pend = 1'b0;
    end
    op_prev = bus.mem_op;
    if (bus.tx_valid) begin
      n_tx++; tx_q.push_back(bus.tx_data); ev_q.push_back(3 << 16);
      bus.tx_ready = 1'b0; uart_hold = 3;
    end else if (uart_hold > 0) begin
      uart_hold--;
      if (uart_hold == 0) bus.tx_ready = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    ev_q.delete(); tx_q.delete(); wr_a.delete(); wr_d.delete();
    n_rd = 0; n_wr = 0; n_tx = 0; n_done = 0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (n_done == 0 && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    if (n_done == 0) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic kick(input logic [1:0] m, input logic [29:0] a0, input logic [29:0] a1,
                      input logic [31:0] pat);
    @(negedge clk);
    mode = m; addr_start = a0; addr_end = a1; fill_pattern = pat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  m;
    logic [29:0] a0, a1;
    logic [31:0] pat;
    int          words, rd, wr, tx;
  } vec_t;

  vec_t vecs[8];
  int   exp_ev[6];

  initial begin
    bus.tx_ready = 1'b1; bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_wc", word_count, 0);
    check("rst_op", bus.mem_op, 0);
    check("rst_rw", bus.mem_rw, 1);
    check("rst_txv", bus.tx_valid, 0);
    reset = 1'b0;

    mem[30'h100] = 32'hA0; mem[30'h104] = 32'hA1; mem[30'h108] = 32'hA2; mem[30'h10C] = 32'hA3;
    mem[30'h40] = 32'h11;  mem[30'h44] = 32'h22;  mem[30'hFFFFFC] = 32'h5A;

    vecs[0] = '{"read4",     2'd0, 30'h100,    30'h10C,      32'h0,        4, 4, 0, 4};
    vecs[1] = '{"fill8",     2'd1, 30'h0,      30'h1C,       32'hDEADBEEF, 8, 0, 8, 0};
    vecs[2] = '{"rdclr",     2'd2, 30'h40,     30'h44,       32'h0,        2, 2, 2, 2};
    vecs[3] = '{"readback",  2'd0, 30'h40,     30'h44,       32'h0,        2, 2, 0, 2};
    vecs[4] = '{"empty",     2'd0, 30'h20,     30'h10,       32'h0,        0, 0, 0, 0};
    vecs[5] = '{"nop",       2'd3, 30'h0,      30'h10,       32'h0,        0, 0, 0, 0};
    vecs[6] = '{"unaligned", 2'd0, 30'h103,    30'h105,      32'h0,        2, 2, 0, 2};
    vecs[7] = '{"clip",      2'd0, 30'hFFFFF8, 30'h3FFFFFFF, 32'h0,        2, 2, 0, 2};
    exp_ev = '{(1 << 16) | 'h40, 3 << 16, (2 << 16) | 'h40,
               (1 << 16) | 'h44, 3 << 16, (2 << 16) | 'h44};

    for (int i = 0; i < 8; i++) begin
      clear_logs();
      kick(vecs[i].m, vecs[i].a0, vecs[i].a1, vecs[i].pat);
      wait_done(vecs[i].name);
      check({vecs[i].name, "_wc"}, word_count, vecs[i].words);
      check({vecs[i].name, "_reads"}, n_rd, vecs[i].rd);
      check({vecs[i].name, "_writes"}, n_wr, vecs[i].wr);
      check({vecs[i].name, "_tx"}, n_tx, vecs[i].tx);
      check({vecs[i].name, "_donecnt"}, n_done, 1);
      check({vecs[i].name, "_aborted"}, aborted, 0);
      case (i)
        0: for (int k = 0; k < 4; k++) check("read4_data", tx_q[k], 32'hA0 + k);
        1: for (int k = 0; k < 8; k++) begin
             check("fill8_addr", wr_a[k], 4 * k);
             check("fill8_data", wr_d[k], 32'hDEADBEEF);
           end
        2: begin
             check("rdclr_events", ev_q.size(), 6);
             for (int k = 0; k < 6; k++) check("rdclr_order", ev_q[k], exp_ev[k]);
             check("rdclr_tx0", tx_q[0], 32'h11);
             check("rdclr_tx1", tx_q[1], 32'h22);
           end
        3: begin
             check("readback0", tx_q[0], 32'h0);
             check("readback1", tx_q[1], 32'h0);
           end
        6: begin
             check("unaligned_tx0", tx_q[0], 32'hA0);
             check("unaligned_tx1", tx_q[1], 32'hA1);
           end
        7: check("clip_lastdata", tx_q[1], 32'h5A);
        default: ;
      endcase
    end

    // Empty range: busy the cycle after start, done (and busy low) one cycle later.
    clear_logs();
    kick(2'd0, 30'h20, 30'h10, 32'h0);
    check("empty_t1_busy", busy, 1);
    check("empty_t1_done", done, 0);
    @(negedge clk);
    check("empty_t2_done", done, 1);
    check("empty_t2_busy", busy, 0);
    @(negedge clk);
    check("empty_t3_done", done, 0);
    check("empty_no_op", n_rd + n_wr, 0);

    // First command appears two cycles after start.
    clear_logs();
    kick(2'd0, 30'h100, 30'h100, 32'h0);
    check("lat_t1_op", bus.mem_op, 0);
    @(negedge clk);
    check("lat_t2_op", bus.mem_op, 1);
    check("lat_t2_addr", bus.mem_addr, 30'h100);
    check("lat_t2_rw", bus.mem_rw, 1);
    wait_done("lat");
    check("lat_tx", tx_q[0], 32'hA0);

    // Abort raised while the third read command is on the bus.
    mem[30'h8] = 32'h33;
    clear_logs();
    kick(2'd0, 30'h0, 30'h3C, 32'h0);
    begin
      int cyc = 0;
      while (n_rd < 3 && cyc < 1000) begin @(negedge clk); cyc++; end
      check("abort_reached_rd3", n_rd, 3);
    end
    abort = 1'b1;
    wait_done("abort");
    abort = 1'b0;
    check("abort_wc", word_count, 3);
    check("abort_tx", n_tx, 3);
    check("abort_tx3", tx_q[2], 32'h33);
    check("abort_reads", n_rd, 3);
    check("abort_flag", aborted, 1);
    check("abort_donecnt", n_done, 1);

    // Reset while the engine waits for UART acceptance.
    clear_logs();
    kick(2'd0, 30'h100, 30'h10C, 32'h0);
    check("start_clears_aborted", aborted, 0);
    begin
      int cyc = 0;
      while (n_tx < 1 && cyc < 1000) begin @(negedge clk); cyc++; end
      check("rst_reached_tx", n_tx, 1);
    end
    #1 reset = 1'b1;
    #1;
    check("mid_tx_data", bus.tx_data, 0);
    check("mid_tx_valid", bus.tx_valid, 0);
    check("mid_mem_addr", bus.mem_addr, 0);
    check("mid_mem_wdata", bus.mem_wdata, 0);
    check("mid_mem_rw", bus.mem_rw, 1);
    check("mid_mem_op", bus.mem_op, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_aborted", aborted, 0);
    check("mid_wc", word_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    clear_logs();
    kick(2'd0, 30'h100, 30'h10C, 32'h0);
    wait_done("after_rst");
    check("after_rst_wc", word_count, 4);
    check("after_rst_tx", n_tx, 4);
    check("after_rst_tx0", tx_q[0], 32'hA0);
    check("after_rst_tx3", tx_q[3], 32'hA3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
